ex_alu_rs: RTL and testbench
============================

EX_ALU_RS -- requirements
Module: ex_alu_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of reservation-station entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port disp_valid_in  input  1  decode offers one instruction.
REQ-005 SHALL have port disp_ready_out  output  1  the station accepts one instruction this cycle.
REQ-006 SHALL have ports disp_op_in (sinst_t), disp_pc_in (addr_t), disp_target_in (regaddr_t), all inputs: the instruction fields.
REQ-007 SHALL have ports disp_tagx_in and disp_tagy_in (regtag_t), plus disp_datax_in and disp_datay_in (word_t), all inputs: operand tags and data; data is valid only when its tag equals UNLOCKED.
REQ-008 SHALL have ports cdb_valid_in (1), cdb_tag_in (regtag_t) and cdb_data_in (word_t), all inputs: the result broadcast.
REQ-009 SHALL have port flush_in  input  1  the ALU jump redirect (en_jmp) kills all pending work.
REQ-010 SHALL have ports issue_valid_out (1), issue_op_out, issue_pc_out, issue_datax_out, issue_datay_out and issue_target_out, all outputs: the registered issue to ex_alu.
REQ-011 SHALL have port issue_ready_in  input  1  ex_alu consumes the issue this cycle.
REQ-012 SHALL have port count_out  output  clog2(DEPTH+1)  occupied entries, excluding the issue register.

Function
REQ-013 SHALL store entries in age order: slot 0 is the oldest; the queue compacts toward slot 0 when an entry is removed.
REQ-014 SHALL assert disp_ready_out = (count_out < DEPTH) && !flush_in; issue-side removal in the same cycle SHALL NOT make an extra slot available.
REQ-015 SHALL, on disp_valid_in && disp_ready_out, write the instruction into the first free slot after the same-cycle compaction.
REQ-016 SHALL, when cdb_valid_in and cdb_tag_in != UNLOCKED, replace the data of every stored operand whose tag equals cdb_tag_in with cdb_data_in and set that tag to UNLOCKED.
REQ-017 SHALL apply the same CDB capture to an instruction dispatched in that cycle, with no lost wakeup.
REQ-018 SHALL treat an entry as ready when both of its tags equal UNLOCKED; readiness reached through a CDB capture counts from the next cycle.
REQ-019 SHALL treat the issue register as free when issue_valid_out == 0 || issue_ready_in.
REQ-020 SHALL, when the issue register is free, move the oldest ready entry into it, set issue_valid_out=1 and remove that entry; if no entry is ready, issue_valid_out SHALL go to 0.
REQ-021 SHALL hold every issue_* output stable while issue_valid_out && !issue_ready_in.
REQ-022 SHALL have a minimum latency of 1: an entry dispatched ready in cycle N SHALL appear on issue_valid_out in cycle N+1 when the queue and the issue register are empty.
REQ-023 SHALL issue at most one instruction per cycle; dispatch, wakeup and issue in the same cycle SHALL all take effect.
REQ-024 SHALL, on flush_in, clear all entries and issue_valid_out next cycle; flush SHALL override dispatch, wakeup and issue in that cycle.
REQ-025 SHALL never lose or duplicate an entry when full: with DEPTH entries and a same-cycle issue, count_out SHALL become DEPTH-1 because dispatch is blocked.

Reset
REQ-026 SHALL, when rst is high at a clock edge, invalidate all entries and drive issue_valid_out=0, count_out=0 and all issue_* data outputs to 0.
REQ-027 SHALL give rst priority over flush_in, dispatch and CDB; the cycle after reset SHALL have disp_ready_out=1.

Structure
REQ-028 SHALL take addr_t, word_t, regtag_t, sinst_t, regaddr_t, UNLOCKED and the opcode constants from the shared defines package; DEPTH SHALL stay local.
REQ-029 SHALL place oldest-ready selection in sub-module ex_alu_rs_pick (ready vector in; one-hot grant and index out; purely combinational).

Verification
REQ-030 SHALL cover: reset, then dispatch ADD with tags UNLOCKED, data 5 and 7 -> next cycle issue_valid_out=1, op=ADD, datax=5, datay=7, count_out=0.
REQ-031 SHALL cover: dispatch with tagx=3, then CDB tag 3, data 0x10 two cycles later -> issue one cycle after the CDB with datax=0x10.
REQ-032 SHALL cover: dispatch in the same cycle as CDB tag 2 for its tagy=2 -> issued next cycle+1 with the captured data and no stall.
REQ-033 SHALL cover: four entries with issue_ready_in=0 -> disp_ready_out=0, count_out=4; then raise issue_ready_in for one cycle -> exactly one issue, outputs stable before it, count_out=3, then dispatch accepted.
REQ-034 SHALL cover: entries A (blocked on tag 4) and B (ready) -> B issues first; CDB tag 4 -> A issues next.
REQ-035 SHALL cover: flush_in with 3 entries plus a held issue and a simultaneous dispatch -> next cycle count_out=0, issue_valid_out=0, and the dispatched instruction is dropped.

Source files
------------

// File: rtl/ex_alu_rs_pkg.sv
// Shared machine types for the ALU reservation station: operand words, register
// tags, instruction encodings and the stored station entry.
package ex_alu_rs_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  regtag_t;
  typedef logic [4:0]  regaddr_t;

  // A tag equal to UNLOCKED means the accompanying data word is valid.
  localparam regtag_t UNLOCKED = 4'd0;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SLT = 4'd7,
    OP_JMP = 4'd8
  } sinst_t;

  typedef struct packed {
    sinst_t   op;
    addr_t    pc;
    regaddr_t target;
    regtag_t  tagx;
    regtag_t  tagy;
    word_t    datax;
    word_t    datay;
  } rs_entry_t;

  // Capture a broadcast result into any operand still waiting on that tag.
  function automatic rs_entry_t rs_wake(rs_entry_t e, logic cv, regtag_t ct, word_t cd);
    rs_entry_t r;
    r = e;
    if (cv && (ct != UNLOCKED)) begin
      if (e.tagx == ct) begin
        r.tagx  = UNLOCKED;
        r.datax = cd;
      end
      if (e.tagy == ct) begin
        r.tagy  = UNLOCKED;
        r.datay = cd;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ex_alu_rs_pick.sv
// Oldest-ready selector: the lowest-numbered ready slot wins, since slot 0 holds
// the oldest entry.
module ex_alu_rs_pick #(
  parameter  int DEPTH = 4,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready_i,
  output logic [DEPTH-1:0] grant_o,
  output logic [IW-1:0]    idx_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    // Scan downward so the last hit, the oldest, is the one that sticks.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ex_alu_rs.sv
// In-order-by-age reservation station feeding ex_alu: dispatch, CDB wakeup,
// oldest-ready issue into a registered issue slot, flush on jump redirect.
module ex_alu_rs
  import ex_alu_rs_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_valid_in,
  output logic          disp_ready_out,
  input  sinst_t        disp_op_in,
  input  addr_t         disp_pc_in,
  input  regaddr_t      disp_target_in,
  input  regtag_t       disp_tagx_in,
  input  regtag_t       disp_tagy_in,
  input  word_t         disp_datax_in,
  input  word_t         disp_datay_in,
  input  logic          cdb_valid_in,
  input  regtag_t       cdb_tag_in,
  input  word_t         cdb_data_in,
  input  logic          flush_in,
  output logic          issue_valid_out,
  output sinst_t        issue_op_out,
  output addr_t         issue_pc_out,
  output word_t         issue_datax_out,
  output word_t         issue_datay_out,
  output regaddr_t      issue_target_out,
  input  logic          issue_ready_in,
  output logic [CW-1:0] count_out
);

  rs_entry_t       ent_q [DEPTH];
  rs_entry_t       ent_d [DEPTH];
  rs_entry_t       issue_q, issue_d;
  logic            issue_valid_q, issue_valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DEPTH-1:0] ready_vec;
  logic [DEPTH-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             issue_free, take, bypass, disp_fire, disp_store;
  logic [CW-1:0]    fill_idx;
  rs_entry_t        disp_raw, disp_e;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ready
      assign ready_vec[gi] = (CW'(gi) < cnt_q) && (ent_q[gi].tagx == UNLOCKED)
                             && (ent_q[gi].tagy == UNLOCKED);
    end
  endgenerate

  ex_alu_rs_pick #(.DEPTH(DEPTH)) u_pick (
    .ready_i (ready_vec),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  assign pick_any       = |pick_grant;
  assign issue_free     = !issue_valid_q || issue_ready_in;
  assign disp_ready_out = (cnt_q < CW'(DEPTH)) && !flush_in;
  assign disp_fire      = disp_valid_in && disp_ready_out;
  assign take           = issue_free && pick_any;
  // A dispatch that arrives fully ready skips the queue when nothing older is waiting.
  assign bypass         = issue_free && !pick_any && disp_fire
                          && (disp_tagx_in == UNLOCKED) && (disp_tagy_in == UNLOCKED);
  assign disp_store     = disp_fire && !bypass;
  assign fill_idx       = cnt_q - CW'(take);

  assign disp_raw = '{op: disp_op_in, pc: disp_pc_in, target: disp_target_in,
                      tagx: disp_tagx_in, tagy: disp_tagy_in,
                      datax: disp_datax_in, datay: disp_datay_in};
  assign disp_e   = rs_wake(disp_raw, cdb_valid_in, cdb_tag_in, cdb_data_in);

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      rs_entry_t src;
      if (gi < DEPTH - 1) begin : g_mid
        logic shift_w;
        assign shift_w = |pick_grant[gi:0];
        assign src     = (take && shift_w) ? ent_q[gi+1] : ent_q[gi];
      end else begin : g_last
        assign src = ent_q[gi];
      end
      assign ent_d[gi] = (disp_store && (fill_idx == CW'(gi))) ? disp_e
                         : rs_wake(src, cdb_valid_in, cdb_tag_in, cdb_data_in);
    end
  endgenerate

  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    if (issue_free) begin
      issue_valid_d = take || bypass;
      if (take) begin
        issue_d = ent_q[pick_idx];
      end else if (bypass) begin
        issue_d = disp_e;
      end
    end
    cnt_d = cnt_q - CW'(take) + CW'(disp_store);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
    end else if (flush_in) begin
      cnt_q         <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
    end
  end

  // Slot contents beyond cnt_q are don't-care, so the storage needs no reset.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign issue_valid_out  = issue_valid_q;
  assign issue_op_out     = issue_q.op;
  assign issue_pc_out     = issue_q.pc;
  assign issue_datax_out  = issue_q.datax;
  assign issue_datay_out  = issue_q.datay;
  assign issue_target_out = issue_q.target;
  assign count_out        = cnt_q;

endmodule

// File: tb/tb_ex_alu_rs.sv
// Bench for ex_alu_rs: directed vector table, hand-written full/flush sequences
// and randomized traffic against a queue-level reference model.
module tb_ex_alu_rs;
  import ex_alu_rs_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush_in, disp_valid_in, cdb_valid_in, issue_ready_in;
  sinst_t disp_op_in;
  addr_t disp_pc_in;
  regaddr_t disp_target_in;
  regtag_t disp_tagx_in, disp_tagy_in, cdb_tag_in;
  word_t disp_datax_in, disp_datay_in, cdb_data_in;
  logic disp_ready_out, issue_valid_out;
  sinst_t issue_op_out;
  addr_t issue_pc_out;
  word_t issue_datax_out, issue_datay_out;
  regaddr_t issue_target_out;
  logic [CW-1:0] count_out;

  ex_alu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
    .disp_op_in(disp_op_in), .disp_pc_in(disp_pc_in), .disp_target_in(disp_target_in),
    .disp_tagx_in(disp_tagx_in), .disp_tagy_in(disp_tagy_in),
    .disp_datax_in(disp_datax_in), .disp_datay_in(disp_datay_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .flush_in(flush_in),
    .issue_valid_out(issue_valid_out), .issue_op_out(issue_op_out),
    .issue_pc_out(issue_pc_out), .issue_datax_out(issue_datax_out),
    .issue_datay_out(issue_datay_out), .issue_target_out(issue_target_out),
    .issue_ready_in(issue_ready_in), .count_out(count_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an age-ordered queue plus one issue register.
  typedef struct {
    sinst_t   op;
    addr_t    pc;
    regaddr_t tgt;
    regtag_t  tx, ty;
    word_t    dx, dy;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t m_is;
  bit     m_iv;
  bit     m_init = 0;
  bit     m_loaded;

  function automatic m_ent_t m_wake(m_ent_t e);
    m_ent_t r = e;
    if (cdb_valid_in && cdb_tag_in != UNLOCKED) begin
      if (r.tx == cdb_tag_in) begin r.tx = UNLOCKED; r.dx = cdb_data_in; end
      if (r.ty == cdb_tag_in) begin r.ty = UNLOCKED; r.dy = cdb_data_in; end
    end
    return r;
  endfunction

  task automatic model_step();
    m_ent_t nd;
    bit free, accept;
    int pick;
    m_loaded = 0;
    if (rst) begin
      mq.delete();
      m_iv   = 0;
      m_is   = '{OP_ADD, 0, 0, 0, 0, 0, 0};
      m_init = 1;
      return;
    end
    if (flush_in) begin
      mq.delete();
      m_iv = 0;
      return;
    end
    nd = '{disp_op_in, disp_pc_in, disp_target_in, disp_tagx_in, disp_tagy_in,
           disp_datax_in, disp_datay_in};
    free   = !m_iv || issue_ready_in;
    accept = disp_valid_in && (mq.size() < DEPTH);
    pick   = -1;
    for (int i = 0; i < mq.size(); i++)
      if (pick < 0 && mq[i].tx == UNLOCKED && mq[i].ty == UNLOCKED) pick = i;
    if (free) begin
      if (pick >= 0) begin
        m_is = mq[pick];
        mq.delete(pick);
        m_iv = 1;
        m_loaded = 1;
      end else if (accept && nd.tx == UNLOCKED && nd.ty == UNLOCKED) begin
        m_is = nd;
        m_iv = 1;
        m_loaded = 1;
        accept = 0;
      end else begin
        m_iv = 0;
      end
    end
    for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
    if (accept) mq.push_back(m_wake(nd));
  endtask

  task automatic cycle();
    #1;
    if (m_init) chk("disp_ready", disp_ready_out, (mq.size() < DEPTH) && !flush_in);
    model_step();
    @(posedge clk);
    #1;
    chk("issue_valid", issue_valid_out, m_iv);
    if (m_iv) begin
      chk("issue_op", issue_op_out, m_is.op);
      chk("issue_pc", issue_pc_out, m_is.pc);
      chk("issue_datax", issue_datax_out, m_is.dx);
      chk("issue_datay", issue_datay_out, m_is.dy);
      chk("issue_target", issue_target_out, m_is.tgt);
    end
    chk("count", count_out, mq.size());
    if (m_loaded)
      $display("issue op=%0d pc=%h x=%h y=%h tgt=%0d cnt=%0d",
               m_is.op, m_is.pc, m_is.dx, m_is.dy, m_is.tgt, mq.size());
  endtask

  task automatic idle();
    rst = 0; flush_in = 0; disp_valid_in = 0; cdb_valid_in = 0;
    disp_tagx_in = 0; disp_tagy_in = 0; cdb_tag_in = 0;
  endtask

  task automatic disp(input sinst_t op, input regtag_t tx, input regtag_t ty,
                      input word_t dx, input word_t dy);
    disp_valid_in = 1; disp_op_in = op; disp_tagx_in = tx; disp_tagy_in = ty;
    disp_datax_in = dx; disp_datay_in = dy;
  endtask

  typedef struct {
    bit rst; bit dv; sinst_t op; regtag_t tx, ty; word_t dx, dy;
    bit cv; regtag_t ct; word_t cd;
    bit e_iv; sinst_t e_op; word_t e_dx, e_dy; int e_cnt;
  } vec_t;

  function automatic vec_t v(bit r, bit dv, sinst_t op, regtag_t tx, regtag_t ty,
                             word_t dx, word_t dy, bit cv, regtag_t ct, word_t cd,
                             bit eiv, sinst_t eop, word_t edx, word_t edy, int ecnt);
    vec_t x;
    x = '{r, dv, op, tx, ty, dx, dy, cv, ct, cd, eiv, eop, edx, edy, ecnt};
    return x;
  endfunction

  vec_t vecs[16];
  word_t held_x, held_y;
  addr_t held_pc;

  initial begin
    vecs[0]  = v(1, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        0, OP_ADD, 0,     0,     0);
    vecs[1]  = v(0, 1, OP_ADD, 0, 0, 5, 7,        0, 0, 0,        1, OP_ADD, 5,     7,     0);
    vecs[2]  = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        0, OP_ADD, 0,     0,     0);
    vecs[3]  = v(0, 1, OP_SUB, 3, 0, 0, 9,        0, 0, 0,        0, OP_ADD, 0,     0,     1);
    vecs[4]  = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        0, OP_ADD, 0,     0,     1);
    vecs[5]  = v(0, 0, OP_ADD, 0, 0, 0, 0,        1, 3, 32'h10,   0, OP_ADD, 0,     0,     1);
    vecs[6]  = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        1, OP_SUB, 32'h10, 9,    0);
    vecs[7]  = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        0, OP_ADD, 0,     0,     0);
    vecs[8]  = v(0, 1, OP_AND, 0, 2, 1, 0,        1, 2, 32'h22,   0, OP_ADD, 0,     0,     1);
    vecs[9]  = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        1, OP_AND, 1,     32'h22, 0);
    vecs[10] = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        0, OP_ADD, 0,     0,     0);
    vecs[11] = v(0, 1, OP_OR,  4, 0, 0, 3,        0, 0, 0,        0, OP_ADD, 0,     0,     1);
    vecs[12] = v(0, 1, OP_XOR, 0, 0, 6, 8,        0, 0, 0,        1, OP_XOR, 6,     8,     1);
    vecs[13] = v(0, 0, OP_ADD, 0, 0, 0, 0,        1, 4, 32'h44,   0, OP_ADD, 0,     0,     1);
    vecs[14] = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        1, OP_OR,  32'h44, 3,    0);
    vecs[15] = v(0, 0, OP_ADD, 0, 0, 0, 0,        0, 0, 0,        0, OP_ADD, 0,     0,     0);

    idle();
    issue_ready_in = 1; disp_op_in = OP_ADD; disp_pc_in = 0; disp_target_in = 0;
    disp_datax_in = 0; disp_datay_in = 0; cdb_data_in = 0;

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; flush_in = 0; disp_valid_in = vecs[i].dv;
      disp_op_in = vecs[i].op; disp_tagx_in = vecs[i].tx; disp_tagy_in = vecs[i].ty;
      disp_datax_in = vecs[i].dx; disp_datay_in = vecs[i].dy;
      disp_pc_in = 32'h1000 + 32'(i * 4); disp_target_in = 5'(i);
      cdb_valid_in = vecs[i].cv; cdb_tag_in = vecs[i].ct; cdb_data_in = vecs[i].cd;
      issue_ready_in = 1;
      cycle();
      chk($sformatf("tbl%0d_iv", i), issue_valid_out, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        chk($sformatf("tbl%0d_op", i), issue_op_out, vecs[i].e_op);
        chk($sformatf("tbl%0d_dx", i), issue_datax_out, vecs[i].e_dx);
        chk($sformatf("tbl%0d_dy", i), issue_datay_out, vecs[i].e_dy);
      end
      chk($sformatf("tbl%0d_cnt", i), count_out, vecs[i].e_cnt);
      if (vecs[i].rst) begin
        chk("rst_datax", issue_datax_out, 0);
        chk("rst_datay", issue_datay_out, 0);
        chk("rst_pc", issue_pc_out, 0);
        chk("rst_target", issue_target_out, 0);
        chk("rst_ready", disp_ready_out, 1);
      end
    end

    // Full station with a stalled consumer, then a single-cycle release.
    idle(); rst = 1; cycle(); idle();
    issue_ready_in = 0;
    for (int k = 0; k < 5; k++) begin
      disp(OP_ADD, 0, 0, 100 + k, 200 + k);
      disp_pc_in = 32'h2000 + 32'(k * 4);
      cycle();
    end
    chk("full_cnt", count_out, 4);
    held_x = issue_datax_out; held_y = issue_datay_out; held_pc = issue_pc_out;
    chk("full_held_x", held_x, 100);
    disp(OP_SUB, 0, 0, 105, 205);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_ready_low", disp_ready_out, 0);
      cycle();
      chk("hold_x", issue_datax_out, held_x);
      chk("hold_y", issue_datay_out, held_y);
      chk("hold_pc", issue_pc_out, held_pc);
      chk("hold_cnt", count_out, 4);
    end
    issue_ready_in = 1;
    cycle();
    chk("release_iv", issue_valid_out, 1);
    chk("release_x", issue_datax_out, 101);
    chk("release_cnt", count_out, 3);
    issue_ready_in = 0;
    #1;
    chk("release_ready", disp_ready_out, 1);
    cycle();
    chk("refill_cnt", count_out, 4);

    // Flush with queued entries, a held issue and a simultaneous dispatch.
    idle(); rst = 1; cycle(); idle();
    issue_ready_in = 0;
    for (int k = 0; k < 4; k++) begin
      disp(OP_OR, 0, 0, 300 + k, 400 + k);
      cycle();
    end
    chk("preflush_cnt", count_out, 3);
    chk("preflush_iv", issue_valid_out, 1);
    disp(OP_XOR, 0, 0, 500, 600);
    flush_in = 1;
    cycle();
    chk("flush_cnt", count_out, 0);
    chk("flush_iv", issue_valid_out, 0);
    idle(); issue_ready_in = 1;
    cycle();
    chk("postflush_cnt", count_out, 0);
    chk("postflush_iv", issue_valid_out, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      flush_in      = ($urandom_range(0, 39) == 0);
      disp_valid_in = ($urandom_range(0, 9) < 6);
      disp_op_in    = sinst_t'(4'($urandom_range(0, 8)));
      disp_pc_in    = $urandom;
      disp_target_in = 5'($urandom_range(0, 31));
      disp_tagx_in  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : UNLOCKED;
      disp_tagy_in  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : UNLOCKED;
      disp_datax_in = $urandom;
      disp_datay_in = $urandom;
      cdb_valid_in  = ($urandom_range(0, 1) == 0);
      cdb_tag_in    = 4'($urandom_range(0, 3));
      cdb_data_in   = $urandom;
      issue_ready_in = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
